// File: rtl/ledmatrix_pkg.sv
// Shared MAX7219 register map, scheduler state encoding and init word table.
package ledmatrix_pkg;

    localparam int N_DEV    = 4;
    localparam int ROWS     = 8;
    localparam int INIT_LEN = 5;

    localparam logic [7:0] REG_DIGIT0    = 8'h01;
    localparam logic [7:0] REG_DIGIT1    = 8'h02;
    localparam logic [7:0] REG_DIGIT2    = 8'h03;
    localparam logic [7:0] REG_DIGIT3    = 8'h04;
    localparam logic [7:0] REG_DIGIT4    = 8'h05;
    localparam logic [7:0] REG_DIGIT5    = 8'h06;
    localparam logic [7:0] REG_DIGIT6    = 8'h07;
    localparam logic [7:0] REG_DIGIT7    = 8'h08;
    localparam logic [7:0] REG_DECODE    = 8'h09;
    localparam logic [7:0] REG_INTENSITY = 8'h0A;
    localparam logic [7:0] REG_SCANLIM   = 8'h0B;
    localparam logic [7:0] REG_SHUTDN    = 8'h0C;
    localparam logic [7:0] REG_DISPTEST  = 8'h0F;

    typedef enum logic [1:0] {
        S_RESET_WAIT,
        S_INIT,
        S_IDLE,
        S_ROWS
    } state_t;

    function automatic logic [15:0] init_word(input logic [2:0] idx, input logic [3:0] inten);
        case (idx)
            3'd0:    return {REG_DECODE, 8'h00};
            3'd1:    return {REG_INTENSITY, 4'h0, inten};
            3'd2:    return {REG_SCANLIM, 8'h07};
            3'd3:    return {REG_SHUTDN, 8'h01};
            default: return {REG_DISPTEST, 8'h00};
        endcase
    endfunction

endpackage

// File: rtl/ledmatrix_convert.sv
// Font datapath: 4 char codes + row index (1..8) -> one {addr,data} word per device.
// Purely combinational; codes outside '0'..'9' render blank.
module ledmatrix_convert
    import ledmatrix_pkg::*;
(
    input  logic [31:0] chars,
    input  logic [3:0]  row,
    output logic [63:0] word
);

    function automatic logic [63:0] glyph(input logic [7:0] code);
        case (code)
            8'h30:   return 64'h3C666E7666663C00;
            8'h31:   return 64'h183818181818_7E00;
            8'h32:   return 64'h3C66060C30607E00;
            8'h33:   return 64'h3C66061C06663C00;
            8'h34:   return 64'h0C1C3C6C7E0C0C00;
            8'h35:   return 64'h7E607C0606663C00;
            8'h36:   return 64'h3C607C6666663C00;
            8'h37:   return 64'h7E060C1830303000;
            8'h38:   return 64'h3C66663C66663C00;
            8'h39:   return 64'h3C66663E060C3800;
            default: return 64'h0;
        endcase
    endfunction

    logic [63:0] shifted;

    // Glyph row 1 is the top byte; shift the wanted row up into [63:56].
    always_comb begin
        word    = '0;
        shifted = '0;
        for (int d = 0; d < N_DEV; d++) begin
            shifted = glyph(chars[31-8*d -: 8]) << {row - 4'd1, 3'b000};
            word[63-16*d -: 16] = {8'(REG_DIGIT0 + {4'h0, row} - 8'd1), shifted[63:56]};
        end
    end

endmodule

// File: rtl/ledmatrix_sched.sv
// Config sequencer + round-robin frame arbiter feeding the MAX7219 SPI shifter; words held until word_ready.
// First init word STARTUP_TICKS cycles after reset release; optional periodic re-init via LEDMATRIX_REINIT_EN.
module ledmatrix_sched
    import ledmatrix_pkg::*;
#(
    parameter int         STARTUP_TICKS = 10,
    parameter logic [3:0] INTENSITY     = 4'hF
`ifdef LEDMATRIX_REINIT_EN
    ,
    parameter int         REINIT_FRAMES = 64
`endif
) (
    input  logic        clk_100Hz,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [31:0] req0_chars,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_chars,
    output logic        req1_ready,
    output logic        word_valid,
    output logic [63:0] word_data,
    input  logic        word_ready,
    output logic        init_done,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    state_t      state;
    logic [15:0] tick_cnt;
    logic [2:0]  init_idx;
    logic [3:0]  row;
    logic [31:0] chars_q;
    logic [63:0] init_data;
    logic [63:0] row_word;
    logic        rr_ptr;
    logic        grant0;
    logic        grant1;
    logic        xfer;
    logic        reinit_due;

`ifdef LEDMATRIX_REINIT_EN
    logic [15:0] since_init;
    assign reinit_due = (since_init == 16'(REINIT_FRAMES - 1));
`else
    assign reinit_due = 1'b0;
`endif

    ledmatrix_convert u_convert (
        .chars (chars_q),
        .row   (row),
        .word  (row_word)
    );

    // rr_ptr names the requester that wins a tie.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == S_IDLE && init_done) begin
            if (req0_valid && (!req1_valid || !rr_ptr))
                grant0 = 1'b1;
            else if (req1_valid)
                grant1 = 1'b1;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign busy       = (state != S_IDLE);
    assign xfer       = word_valid && word_ready;
    assign word_data  = (state == S_ROWS) ? row_word : init_data;

    always_ff @(posedge clk_100Hz) begin
        if (!rst_n) begin
            state      <= S_RESET_WAIT;
            tick_cnt   <= '0;
            init_idx   <= '0;
            row        <= '0;
            chars_q    <= '0;
            init_data  <= '0;
            word_valid <= 1'b0;
            init_done  <= 1'b0;
            frame_cnt  <= '0;
            rr_ptr     <= 1'b0;
`ifdef LEDMATRIX_REINIT_EN
            since_init <= '0;
`endif
        end else begin
            case (state)
                S_RESET_WAIT: begin
                    if (tick_cnt == 16'(STARTUP_TICKS - 1)) begin
                        state      <= S_INIT;
                        init_idx   <= '0;
                        init_data  <= {N_DEV{init_word(3'd0, INTENSITY)}};
                        word_valid <= 1'b1;
                    end else begin
                        tick_cnt <= tick_cnt + 16'd1;
                    end
                end
                S_INIT: begin
                    if (xfer) begin
                        if (init_idx == 3'(INIT_LEN - 1)) begin
                            word_valid <= 1'b0;
                            init_done  <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            init_idx  <= init_idx + 3'd1;
                            init_data <= {N_DEV{init_word(init_idx + 3'd1, INTENSITY)}};
                        end
                    end
                end
                S_IDLE: begin
                    if (grant0 || grant1) begin
                        chars_q    <= grant0 ? req0_chars : req1_chars;
                        rr_ptr     <= grant0;
                        row        <= 4'd1;
                        word_valid <= 1'b1;
                        state      <= S_ROWS;
                    end
                end
                S_ROWS: begin
                    if (xfer) begin
                        if (row == 4'(ROWS)) begin
                            frame_cnt <= frame_cnt + 16'd1;
                            // A due re-init goes straight to INIT so no grant slips in first.
                            if (reinit_due) begin
                                state     <= S_INIT;
                                init_idx  <= '0;
                                init_data <= {N_DEV{init_word(3'd0, INTENSITY)}};
                            end else begin
                                word_valid <= 1'b0;
                                state      <= S_IDLE;
                            end
`ifdef LEDMATRIX_REINIT_EN
                            since_init <= reinit_due ? 16'd0 : since_init + 16'd1;
`endif
                        end else begin
                            row <= row + 4'd1;
                        end
                    end
                end
                default: state <= S_RESET_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_ledmatrix_sched.sv
// Directed sequence with randomized chars/backpressure, checked against a spec-level frame model.
module tb_ledmatrix_sched;

    logic        clk_100Hz = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0;
    logic [31:0] req0_chars = '0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [31:0] req1_chars = '0;
    logic        req1_ready;
    logic        word_valid;
    logic [63:0] word_data;
    logic        word_ready = 1'b0;
    logic        init_done;
    logic        busy;
    logic [15:0] frame_cnt;

    int checks = 0;
    int failures = 0;
    int exp_frames = 0;
    int fsi = 0;
    int last_grant = 1;

`ifdef LEDMATRIX_REINIT_EN
    localparam int REINIT = 2;
`endif

    logic [63:0] digits [10] = '{
        64'h3C666E7666663C00, 64'h1838181818187E00, 64'h3C66060C30607E00,
        64'h3C66061C06663C00, 64'h0C1C3C6C7E0C0C00, 64'h7E607C0606663C00,
        64'h3C607C6666663C00, 64'h7E060C1830303000, 64'h3C66663C66663C00,
        64'h3C66663E060C3800};
    logic [15:0] init_tab [5] = '{16'h0900, 16'h0A0F, 16'h0B07, 16'h0C01, 16'h0F00};

    ledmatrix_sched #(
        .STARTUP_TICKS (10),
        .INTENSITY     (4'hF)
`ifdef LEDMATRIX_REINIT_EN
        ,
        .REINIT_FRAMES (REINIT)
`endif
    ) dut (
        .clk_100Hz  (clk_100Hz),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_chars (req0_chars),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_chars (req1_chars),
        .req1_ready (req1_ready),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_ready (word_ready),
        .init_done  (init_done),
        .busy       (busy),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk_100Hz = ~clk_100Hz;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_100Hz);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] glyph(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return digits[int'(c) - 48];
        return 64'h0;
    endfunction

    function automatic logic [63:0] exp_row(input logic [31:0] ch, input int r);
        logic [63:0] res, g;
        res = '0;
        for (int d = 0; d < 4; d++) begin
            g = glyph(ch[31-8*d -: 8]);
            res[63-16*d -: 16] = {8'(r), g[63-8*(r-1) -: 8]};
        end
        return res;
    endfunction

    function automatic logic [31:0] rand_chars();
        logic [31:0] ch;
        for (int d = 0; d < 4; d++) begin
            case ($urandom_range(3))
                0:       ch[8*d +: 8] = 8'h00;
                3:       ch[8*d +: 8] = 8'($urandom_range(255));
                default: ch[8*d +: 8] = 8'(48 + $urandom_range(9));
            endcase
        end
        return ch;
    endfunction

    // Waits for one transfer, checking valid/data hold steady while stalled.
    task automatic get_word(output logic [63:0] w, input int low_pct);
        logic v, stalled, got;
        logic [63:0] d, held;
        stalled = 1'b0; held = '0; got = 1'b0; w = '0; v = 1'b0;
        for (int c = 0; c < 200; c++) begin
            word_ready = ($urandom_range(99) >= low_pct);
            v = word_valid;
            d = word_data;
            if (stalled) begin
                chk("stall_valid", 64'(v), 64'(1));
                chk("stall_data", d, held);
            end
            tick();
            if (v && word_ready) begin
                w = d;
                return;
            end
            stalled = v;
            held = d;
        end
        chk("word_timeout", 64'(got), 64'(1));
    endtask

    task automatic collect_init(input int low_pct);
        logic [63:0] w;
        for (int i = 0; i < 5; i++) begin
            get_word(w, low_pct);
            chk($sformatf("init_word%0d", i), w, {4{init_tab[i]}});
        end
        chk("init_done", 64'(init_done), 64'(1));
        chk("busy_idle", 64'(busy), 64'(0));
    endtask

    task automatic collect_frame(input logic [31:0] ch, input int low_pct);
        logic [63:0] w;
        for (int r = 1; r <= 8; r++) begin
            get_word(w, low_pct);
            chk($sformatf("row%0d", r), w, exp_row(ch, r));
        end
        exp_frames++;
        chk("frame_cnt", 64'(frame_cnt), 64'(exp_frames));
`ifdef LEDMATRIX_REINIT_EN
        fsi++;
        if (fsi == REINIT) begin
            fsi = 0;
            collect_init(low_pct);
        end
`endif
    endtask

    task automatic wait_grant(output int who);
        who = -1;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (req0_ready || req1_ready) begin
                who = req0_ready ? 0 : 1;
                chk("grant_onehot", 64'(req0_ready && req1_ready), 64'(0));
                last_grant = who;
                tick();
                chk("ready_pulse", 64'({req0_ready, req1_ready}), 64'(0));
                chk("first_row_lat", 64'(word_valid), 64'(1));
                return;
            end
            tick();
        end
        chk("grant_timeout", 64'(who), 64'(0));
    endtask

    task automatic release_and_init();
        int c;
        exp_frames = 0;
        fsi = 0;
        last_grant = 1;
        word_ready = 1'b1;
        rst_n = 1'b1;
        c = 0;
        while (!word_valid && c < 50) begin
            chk("no_grant_before_init", 64'({req0_ready, req1_ready, init_done}), 64'(0));
            tick();
            c++;
        end
        chk("startup_latency", 64'(c), 64'(10));
        collect_init(0);
    endtask

    initial begin
        int who, expw;
        logic [31:0] ch;
        logic [63:0] w;

        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_word_valid", 64'(word_valid), 64'(0));
        chk("rst_word_data", word_data, 64'(0));
        chk("rst_ready", 64'({req0_ready, req1_ready}), 64'(0));
        chk("rst_init_done", 64'(init_done), 64'(0));
        chk("rst_frame_cnt", 64'(frame_cnt), 64'(0));
        chk("rst_busy", 64'(busy), 64'(1));
        release_and_init();

        // Blank frame, then the stalled "01" frame.
        req0_chars = 32'h0; req0_valid = 1'b1;
        wait_grant(who);
        chk("grant_who", 64'(who), 64'(0));
        req0_valid = 1'b0;
        collect_frame(32'h0, 0);
        word_ready = 1'b1;
        repeat (3) begin
            chk("idle_no_word", 64'(word_valid), 64'(0));
            tick();
        end

        req0_chars = 32'h00313000; req0_valid = 1'b1;
        wait_grant(who);
        chk("grant_who", 64'(who), 64'(0));
        req0_valid = 1'b0;
        collect_frame(32'h00313000, 30);
`ifndef LEDMATRIX_REINIT_EN
        word_ready = 1'b1;
        repeat (3) begin
            chk("no_reinit", 64'(word_valid), 64'(0));
            tick();
        end
`endif

        for (int i = 0; i < 3; i++) begin
            expw = $urandom_range(1);
            ch = rand_chars();
            if (expw == 0) begin req0_chars = ch; req0_valid = 1'b1; end
            else begin req1_chars = ch; req1_valid = 1'b1; end
            wait_grant(who);
            chk("single_grant", 64'(who), 64'(expw));
            req0_valid = 1'b0; req1_valid = 1'b0;
            collect_frame(ch, 20);
        end

        // Both requesters held valid: grants must alternate.
        req0_chars = rand_chars(); req1_chars = rand_chars();
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expw = 1 - last_grant;
            wait_grant(who);
            chk("rr_alternate", 64'(who), 64'(expw));
            ch = (who == 1) ? req1_chars : req0_chars;
            if (who == 1) req1_chars = rand_chars(); else req0_chars = rand_chars();
            collect_frame(ch, 25);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Reset while row 4 is on the bus.
        ch = rand_chars();
        req0_chars = ch; req0_valid = 1'b1;
        wait_grant(who);
        chk("grant_who", 64'(who), 64'(0));
        for (int r = 1; r <= 3; r++) begin
            get_word(w, 0);
            chk("pre_reset_row", w, exp_row(ch, r));
        end
        chk("row4_presented", word_data, exp_row(ch, 4));
        rst_n = 1'b0;
        tick();
        chk("reset_drop_valid", 64'(word_valid), 64'(0));
        chk("reset_frame_cnt", 64'(frame_cnt), 64'(0));
        req1_valid = 1'b1;
        release_and_init();
        wait_grant(who);
        chk("after_reset_grant", 64'(who), 64'(0));
        req0_valid = 1'b0;
        collect_frame(ch, 0);
        expw = 1 - last_grant;
        wait_grant(who);
        chk("pending_req1", 64'(who), 64'(expw));
        req1_valid = 1'b0;
        collect_frame(req1_chars, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
